mem_access_ctrl: RTL

//   Load/store controller between the MEM pipeline stage and data_mem. Accepts one

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a 64-bit word-wide data memory.
// Sub-dword stores are done as read-modify-write because the memory only writes whole words.
module mem_access_ctrl #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_addr,
    inout  wire  [WORD-1:0] mem_data
);

    typedef enum logic [2:0] {IDLE, RD, MERGE_WR, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [2:0]        off_q, off_d;
    logic [WORD-1:0]   wdata_q, wdata_d;
    logic [WORD-1:0]   out_data_q, out_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [WORD-1:0]   mem_addr_q, mem_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [WORD-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return {{(WORD-8){1'b0}}, 8'hFF};
            2'b01:   return {{(WORD-16){1'b0}}, 16'hFFFF};
            2'b10:   return {{(WORD-32){1'b0}}, 32'hFFFF_FFFF};
            default: return {WORD{1'b1}};
        endcase
    endfunction

    function automatic logic [WORD-1:0] extract(input logic [WORD-1:0] data,
                                                input logic [1:0] size,
                                                input logic sgn,
                                                input logic [2:0] off);
        logic [WORD-1:0] f;
        f = data >> {off, 3'b000};
        case (size)
            2'b00:   return {{(WORD-8){sgn & f[7]}}, f[7:0]};
            2'b01:   return {{(WORD-16){sgn & f[15]}}, f[15:0]};
            2'b10:   return {{(WORD-32){sgn & f[31]}}, f[31:0]};
            default: return f;
        endcase
    endfunction

    // Replace only the addressed little-endian lanes of the word read back from memory.
    function automatic logic [WORD-1:0] merge(input logic [WORD-1:0] old,
                                              input logic [WORD-1:0] wdata,
                                              input logic [1:0] size,
                                              input logic [2:0] off);
        logic [WORD-1:0] m;
        m = size_mask(size) << {off, 3'b000};
        return (old & ~m) | ((wdata << {off, 3'b000}) & m);
    endfunction

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        out_data_d  = out_data_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    off_d      = req_addr[2:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = {req_addr[WORD-1:3], 3'b000};
                    if (misaligned(req_size, req_addr[2:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && req_size == 2'b11) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        out_data_d  = req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            RD: begin
                // The read word is consumed at this edge, so it never needs its own buffer.
                if (we_q) begin
                    state_d     = MERGE_WR;
                    mem_write_d = 1'b1;
                    out_data_d  = merge(mem_data, wdata_q, size_q, off_q);
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = extract(mem_data, size_q, signed_q, off_q);
                end
            end
            MERGE_WR, WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 3'b000;
            wdata_q     <= '0;
            out_data_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            out_data_q  <= out_data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_write_q ? out_data_q : {WORD{1'bz}};

endmodule
